// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and memory stages of a pipeline.
// Define MEM_ARB_FAIR_EN to alternate grants under contention instead of always favouring data.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_valid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              StallF,
    output logic              StallM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, D_WAIT, I_WAIT} state_e;

    state_e              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                discard_q, discard_d;
    logic                want_i;
    logic                grant_d, grant_i;

    // A flushed fetch request is not worth starting.
    assign want_i = if_req & ~if_flush;

`ifdef MEM_ARB_FAIR_EN
    logic last_d_q, last_d_d;   // 1 = data stage won the most recent grant

    always_comb begin
        grant_d = d_req & (~want_i | ~last_d_q);
        grant_i = want_i & (~d_req | last_d_q);
    end

    always_comb begin
        last_d_d = last_d_q;
        if (state_q == IDLE && (grant_d || grant_i))
            last_d_d = grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) last_d_q <= 1'b0;
        else       last_d_q <= last_d_d;
    end
`else
    always_comb begin
        grant_d = d_req;
        grant_i = want_i & ~d_req;
    end
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        discard_d   = discard_q;
        if_valid    = 1'b0;
        d_valid     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d     = D_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (grant_i) begin
                    state_d    = I_WAIT;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                end
            end
            D_WAIT: begin
                if (mem_ack) begin
                    d_valid   = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            I_WAIT: begin
                // A flush in the ack cycle itself must also kill the returning word.
                discard_d = discard_q | if_flush;
                if (mem_ack) begin
                    if_valid  = ~(discard_q | if_flush);
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (reset) begin
            if_valid = 1'b0;
            d_valid  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            discard_q   <= discard_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;
    assign StallF    = if_req & ~if_valid & ~if_flush;
    assign StallM    = d_req & ~d_valid;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning memory data width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port if_req  input  1  fetch stage requests an instruction read.
REQ-006 SHALL have port if_addr  input  ADDR_W  fetch address (PCF).
REQ-007 SHALL have port if_flush  input  1  branch taken; cancel pending or in-flight fetch.
REQ-008 SHALL have port if_valid  output  1  fetch data returned this cycle.
REQ-009 SHALL have port if_rdata  output  DATA_W  instruction word.
REQ-010 SHALL have port d_req  input  1  memory stage requests a load/store.
REQ-011 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-012 SHALL have port d_addr  input  ADDR_W  data address (ALUResultM).
REQ-013 SHALL have port d_wdata  input  DATA_W  store data (WriteDataM).
REQ-014 SHALL have port d_valid  output  1  data access completes this cycle.
REQ-015 SHALL have port d_rdata  output  DATA_W  load data.
REQ-016 SHALL have port StallF  output  1  = if_req & ~if_valid & ~if_flush.
REQ-017 SHALL have port StallM  output  1  = d_req & ~d_valid.
REQ-018 SHALL have ports mem_req (output 1), mem_we (output 1), mem_addr (output ADDR_W), mem_wdata (output DATA_W), mem_ack (input 1), mem_rdata (input DATA_W) to the shared single-port memory.

Function
REQ-019 SHALL implement FSM states IDLE, D_WAIT, I_WAIT.
REQ-020 SHALL treat requests as level: requester holds req and payload stable until its valid pulse.
REQ-021 SHALL, in IDLE with d_req=1, register d payload onto mem_*, set mem_req=1 next cycle, go to D_WAIT.
REQ-022 SHALL, in IDLE with d_req=0, if_req=1, if_flush=0, register if_addr (mem_we=0), set mem_req=1, go to I_WAIT.
REQ-023 SHALL hold mem_req, mem_we, mem_addr, mem_wdata constant in D_WAIT/I_WAIT until mem_ack=1.
REQ-024 SHALL, on mem_ack in D_WAIT, combinationally drive d_valid=1 and d_rdata=mem_rdata that cycle, deassert mem_req next cycle, return to IDLE.
REQ-025 SHALL, on mem_ack in I_WAIT, drive if_valid=1, if_rdata=mem_rdata unless the discard flag is set, then return to IDLE.
REQ-026 SHALL set a discard flag when if_flush=1 in I_WAIT (including the ack cycle); flag suppresses if_valid and clears on leaving I_WAIT.
REQ-027 SHALL ignore mem_ack while in IDLE (no valid pulse, no state change).
REQ-028 SHALL re-arbitrate only in IDLE; minimum access latency is request-seen cycle N, mem_req at N+1, valid at earliest ack cycle (N+1 if memory acks immediately).
REQ-029 SHALL hold mem_req=0 for one IDLE cycle between any two accesses.
REQ-030 SHALL drive d_valid for stores exactly as for loads; d_rdata content then unspecified.

Reset
REQ-031 SHALL on reset=1 go to IDLE, clear mem_req, mem_we, discard flag, last-grant register, and drive if_valid=0, d_valid=0 regardless of mem_ack.
REQ-032 SHALL, when reset asserts mid-access, abandon the access; a late mem_ack after reset is ignored per REQ-027.
REQ-033 SHALL reset mem_addr, mem_wdata to 0.

Configuration
REQ-034 SHALL provide macro MEM_ARB_FAIR_EN.
REQ-035 SHALL, with MEM_ARB_FAIR_EN defined, keep a 1-bit last-grant register; when d_req and if_req (unflushed) are both pending in IDLE, grant the requester not granted last.
REQ-036 SHALL, without MEM_ARB_FAIR_EN, always prioritise data over fetch (REQ-021/022); no last-grant register is synthesised.

Verification
REQ-037 SHALL test: if_req=1, if_addr=0x10, memory acks 2 cycles after mem_req with 0xE3A01005 -> mem_addr=0x10, mem_we=0, if_valid=1 with if_rdata=0xE3A01005, StallF high until that cycle.
REQ-038 SHALL test: d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF concurrent with if_req=1 -> store issued first, StallF=1 throughout, fetch issued in cycle after IDLE gap.
REQ-039 SHALL test: if_flush=1 while I_WAIT on 0x20 -> no if_valid on ack, next fetch at new if_addr=0x80 issued after IDLE.
REQ-040 SHALL test: reset pulsed during D_WAIT, then mem_ack=1 -> mem_req=0, d_valid=0, state IDLE.
REQ-041 SHALL test: d_req and if_req held high 4 accesses, MEM_ARB_FAIR_EN defined -> grants D,I,D,I; undefined -> D,D,D,D with StallF=1.
